// File: rtl/stopwatch_pkg.sv
// Shared constants and state encoding for the stopwatch run-control slice.
package stopwatch_pkg;

    localparam int unsigned BCD_W            = 12;
    localparam int unsigned TICK_DIV_DEFAULT = 5_000_000;
    localparam int unsigned PRE_W_DEFAULT    = 23;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        LAP    = 2'd2,
        PAUSED = 2'd3
    } sw_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Decisecond prescaler: counts enabled cycles and emits a one-cycle tick
// every TICK_DIV enabled cycles. The count holds while disabled.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = stopwatch_pkg::TICK_DIV_DEFAULT,
    parameter int unsigned PRE_W    = stopwatch_pkg::PRE_W_DEFAULT
) (
    input  logic clk,
    input  logic reset_key,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [PRE_W-1:0] LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] count;

    // Count enabled cycles; wrap at LAST and register a tick on the wrap.
    always_ff @(posedge clk) begin
        if (!reset_key || clr) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
                tick  <= 1'b1;
            end else begin
                count <= count + PRE_W'(1);
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control sequencer: button FSM, lap capture, display mux,
// and the decisecond tick / counter-clear strobes for the BCD datapath.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = stopwatch_pkg::TICK_DIV_DEFAULT,
    parameter int unsigned PRE_W    = stopwatch_pkg::PRE_W_DEFAULT,
    parameter int unsigned BCD_W    = stopwatch_pkg::BCD_W
) (
    input  logic             clk,
    input  logic             reset_key,
    input  logic             start_stop_p,
    input  logic             lap_reset_p,
    input  logic [BCD_W-1:0] time_bcd,
    output logic             tick,
    output logic             cnt_clear,
    output logic             running,
    output logic             disp_frozen,
    output logic [BCD_W-1:0] disp_bcd,
    output logic [3:0]       lap_cnt
);

    import stopwatch_pkg::*;

    sw_state_t        state;
    sw_state_t        state_next;
    logic             lap_take;
    logic             lap_clear;
    logic             pre_en;
    logic [BCD_W-1:0] lap_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_key) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: start/stop has priority; a simultaneous lap pulse is dropped.
    always_comb begin
        state_next = state;
        if (start_stop_p) begin
            case (state)
                IDLE, PAUSED: state_next = RUN;
                RUN, LAP:     state_next = PAUSED;
                default:      state_next = IDLE;
            endcase
        end else if (lap_reset_p) begin
            case (state)
                RUN:     state_next = LAP;
                LAP:     state_next = RUN;
                PAUSED:  state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    // State-derived outputs and per-cycle control strobes.
    always_comb begin
        running     = (state == RUN) || (state == LAP);
        disp_frozen = (state == LAP);
        lap_take    = (state == RUN) && lap_reset_p && !start_stop_p;
        lap_clear   = (state == PAUSED) && lap_reset_p && !start_stop_p;
        // The edge that leaves RUN/LAP for PAUSED must not advance the prescaler.
        pre_en      = running && !start_stop_p;
    end

    // Lap capture, saturating lap counter and registered counter clear.
    always_ff @(posedge clk) begin
        if (!reset_key) begin
            lap_reg   <= '0;
            lap_cnt   <= '0;
            cnt_clear <= 1'b1;
        end else begin
            cnt_clear <= lap_clear;
            if (lap_clear) begin
                lap_reg <= '0;
                lap_cnt <= '0;
            end else if (lap_take) begin
                lap_reg <= time_bcd;
                if (lap_cnt != 4'hF) begin
                    lap_cnt <= lap_cnt + 4'd1;
                end
            end
        end
    end

    assign disp_bcd = disp_frozen ? lap_reg : time_bcd;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV),
        .PRE_W   (PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset_key(reset_key),
        .en       (pre_en),
        .clr      (lap_clear),
        .tick     (tick)
    );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_DIV=4: directed scenarios
// followed by random button/reset traffic against a behavioural model.
module tb_stopwatch_ctrl;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        reset_key;
    logic        start_stop_p;
    logic        lap_reset_p;
    logic [11:0] time_bcd;
    logic        tick;
    logic        cnt_clear;
    logic        running;
    logic        disp_frozen;
    logic [11:0] disp_bcd;
    logic [3:0]  lap_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: elapsed counts running cycles since the last clear;
    // a tick falls on every multiple of TD.
    bit          m_run, m_frozen, m_paused;
    int          m_elapsed, m_laps;
    logic [11:0] m_lapv;
    bit          m_tick, m_clr;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .TICK_DIV(TD),
        .PRE_W   (2),
        .BCD_W   (12)
    ) dut (
        .clk         (clk),
        .reset_key   (reset_key),
        .start_stop_p(start_stop_p),
        .lap_reset_p (lap_reset_p),
        .time_bcd    (time_bcd),
        .tick        (tick),
        .cnt_clear   (cnt_clear),
        .running     (running),
        .disp_frozen (disp_frozen),
        .disp_bcd    (disp_bcd),
        .lap_cnt     (lap_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst_n, input bit ss, input bit lp, input logic [11:0] t);
        if (!rst_n) begin
            m_run = 0; m_frozen = 0; m_paused = 0;
            m_elapsed = 0; m_laps = 0; m_lapv = '0;
            m_tick = 0; m_clr = 1;
            return;
        end
        m_tick = 0;
        m_clr  = 0;
        if (m_run && !ss) begin
            m_elapsed++;
            if (m_elapsed % TD == 0) m_tick = 1;
        end
        if (ss) begin
            if (m_run) begin
                m_run = 0; m_frozen = 0; m_paused = 1;
            end else begin
                m_run = 1; m_frozen = 0; m_paused = 0;
            end
        end else if (lp) begin
            if (m_run && !m_frozen) begin
                m_frozen = 1;
                m_lapv   = t;
                m_laps   = (m_laps < 15) ? m_laps + 1 : 15;
            end else if (m_run) begin
                m_frozen = 0;
            end else if (m_paused) begin
                m_paused = 0; m_elapsed = 0; m_laps = 0; m_lapv = '0; m_clr = 1;
            end
        end
    endtask

    task automatic step(input bit ss, input bit lp, input logic [11:0] t, input bit rst_n);
        reset_key    = rst_n;
        start_stop_p = ss;
        lap_reset_p  = lp;
        time_bcd     = t;
        @(posedge clk);
        #1;
        model_edge(rst_n, ss, lp, t);
        check_eq("tick",        32'(tick),        32'(m_tick));
        check_eq("cnt_clear",   32'(cnt_clear),   32'(m_clr));
        check_eq("running",     32'(running),     32'(m_run));
        check_eq("disp_frozen", 32'(disp_frozen), 32'(m_frozen));
        check_eq("disp_bcd",    32'(disp_bcd),    32'(m_frozen ? m_lapv : t));
        check_eq("lap_cnt",     32'(lap_cnt),     32'(m_laps));
    endtask

    task automatic idle(input logic [11:0] t);
        step(0, 0, t, 1);
    endtask

    initial begin
        reset_key = 0; start_stop_p = 0; lap_reset_p = 0; time_bcd = '0;
        m_run = 0; m_frozen = 0; m_paused = 0; m_elapsed = 0; m_laps = 0;
        m_lapv = '0; m_tick = 0; m_clr = 0;

        // 1: reset, start, ticks on cycles 4, 8, 12 after entry only.
        step(0, 0, 12'h000, 0);
        check_eq("s1_rst_clear", 32'(cnt_clear), 32'd1);
        check_eq("s1_rst_run",   32'(running),   32'd0);
        step(1, 0, 12'h000, 1);
        check_eq("s1_running", 32'(running), 32'd1);
        for (int c = 1; c <= 12; c++) begin
            idle(12'h000);
            check_eq("s1_tick", 32'(tick), 32'((c % TD) == 0));
        end

        // 2: lap freezes the display, second lap resumes tracking.
        step(0, 1, 12'h123, 1);
        check_eq("s2_frozen", 32'(disp_frozen), 32'd1);
        check_eq("s2_lapcnt", 32'(lap_cnt),     32'd1);
        idle(12'h130);
        check_eq("s2_hold", 32'(disp_bcd), 32'h123);
        step(0, 1, 12'h130, 1);
        check_eq("s2_track", 32'(disp_bcd), 32'h130);

        // 3: pause at prescaler 2, resume, first tick exactly 2 cycles later.
        step(0, 0, 12'h000, 0);
        step(1, 0, 12'h000, 1);
        idle(12'h000);
        idle(12'h000);
        step(1, 0, 12'h000, 1);
        for (int c = 0; c < 10; c++) idle(12'h000);
        step(1, 0, 12'h000, 1);
        idle(12'h000);
        check_eq("s3_tick1", 32'(tick), 32'd0);
        idle(12'h000);
        check_eq("s3_tick2", 32'(tick), 32'd1);

        // 4: paused + lap clears for one cycle; a further lap is ignored.
        step(1, 0, 12'h045, 1);
        step(0, 1, 12'h045, 1);
        check_eq("s4_clear", 32'(cnt_clear), 32'd1);
        check_eq("s4_idle",  32'(running),   32'd0);
        check_eq("s4_laps",  32'(lap_cnt),   32'd0);
        idle(12'h000);
        check_eq("s4_clear_off", 32'(cnt_clear), 32'd0);
        step(0, 1, 12'h000, 1);
        check_eq("s4_ignored", 32'(cnt_clear), 32'd0);

        // 5: simultaneous start/stop and lap: stop wins, lap dropped.
        step(1, 0, 12'h000, 1);
        step(0, 1, 12'h007, 1);
        step(0, 1, 12'h008, 1);
        step(1, 1, 12'h009, 1);
        check_eq("s5_running", 32'(running),     32'd0);
        check_eq("s5_frozen",  32'(disp_frozen), 32'd0);
        check_eq("s5_laps",    32'(lap_cnt),     32'd1);

        // 6: saturate lap_cnt at 15 in LAP, then reset.
        step(0, 0, 12'h000, 0);
        step(1, 0, 12'h000, 1);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 12'(i), 1);
            step(0, 1, 12'(i), 1);
        end
        step(0, 1, 12'h321, 1);
        check_eq("s6_sat",    32'(lap_cnt),     32'd15);
        check_eq("s6_frozen", 32'(disp_frozen), 32'd1);
        step(0, 0, 12'h321, 0);
        check_eq("s6_clear", 32'(cnt_clear), 32'd1);
        check_eq("s6_laps",  32'(lap_cnt),   32'd0);
        check_eq("s6_tick",  32'(tick),      32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 8) == 0, ($urandom % 5) == 0,
                 12'($urandom), ($urandom % 97) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
